matmul_stream_engine: RTL and testbench

- Parametrised successor to the SPI-fed matrix multiplier top.
- Matrices A and B arrive on one valid/ready input stream and are stored in internal buffers. C = A×B is computed with a single integer MAC and leaves on a valid/ready output stream with backpressure.
- Adds runtime signed/unsigned mode, dimension checking, abort, and configurable data, accumulator and output widths.
- Sits between a host-side stream adapter (SPI or DMA) and the result sender.

---
 rtl/matmul_stream_engine_if.sv | 29 ++
 rtl/matmul_stream_engine.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_matmul_stream_engine.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_stream_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : matmul_stream_engine_if
// Purpose  : Operand input stream and result output stream of the engine.
// Revision : 1.0
// ============================================================================
interface matmul_stream_engine_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/matmul_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : matmul_stream_engine
// Purpose  : Streamed C = A x B with buffered operands and one integer MAC.
//            Optional MATMUL_SAT_EN saturates results to OUT_W (adds sat_seen).
// Revision : 1.0
// ============================================================================
module matmul_stream_engine #(
  parameter int MAX_M  = 16,
  parameter int MAX_K  = 16,
  parameter int MAX_N  = 16,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   is_signed,
  input  logic [$clog2(MAX_M):0] M_in,
  input  logic [$clog2(MAX_K):0] K_in,
  input  logic [$clog2(MAX_N):0] N_in,
  matmul_stream_engine_if.slave  s_if,
  output logic                   busy,
  output logic                   done,
`ifdef MATMUL_SAT_EN
  output logic                   sat_seen,
`endif
  output logic                   err
);

  localparam int c_mw = $clog2(MAX_M) + 1;
  localparam int c_kw = $clog2(MAX_K) + 1;
  localparam int c_nw = $clog2(MAX_N) + 1;
  localparam int c_mi = (MAX_M > 1) ? $clog2(MAX_M) : 1;
  localparam int c_ki = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int c_ni = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [c_mw-1:0] c_max_m = c_mw'(MAX_M);
  localparam logic [c_kw-1:0] c_max_k = c_kw'(MAX_K);
  localparam logic [c_nw-1:0] c_max_n = c_nw'(MAX_N);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_A  = 2'd1,
    S_LOAD_B  = 2'd2,
    S_COMPUTE = 2'd3
  } state_t;

  state_t            state_q;
  logic [c_mw-1:0]   m_q, ci_q;
  logic [c_kw-1:0]   k_q, ck_q;
  logic [c_nw-1:0]   n_q, cj_q;
  logic              sgn_q;
  logic              in_ready_q, out_valid_q, out_last_q, done_q, err_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              rd_v_q, rd_first_q, rd_last_q, rd_lastel_q;
  logic              seq_done_q, acc_done_q, acc_last_q;
  logic [DATA_W-1:0] a_rd_q, b_rd_q;
  logic [ACC_W-1:0]  acc_q;

  logic [DATA_W-1:0] a_mem [MAX_M][MAX_K];
  logic [DATA_W-1:0] b_mem [MAX_K][MAX_N];

  logic              in_fire, out_fire, stall, load_out, start_bad;
  logic [ACC_W-1:0]  a_ext, b_ext, prod;
  logic [OUT_W-1:0]  conv;

  assign in_fire   = s_if.in_valid && in_ready_q;
  assign out_fire  = out_valid_q && s_if.out_ready;
  // A finished sum may only wait while the output register is still occupied.
  assign stall     = acc_done_q && out_valid_q && !s_if.out_ready;
  assign load_out  = acc_done_q && !stall;
  assign start_bad = (M_in == '0) || (K_in == '0) || (N_in == '0) ||
                     (M_in > c_max_m) || (K_in > c_max_k) || (N_in > c_max_n);

  assign a_ext = {{(ACC_W-DATA_W){sgn_q & a_rd_q[DATA_W-1]}}, a_rd_q};
  assign b_ext = {{(ACC_W-DATA_W){sgn_q & b_rd_q[DATA_W-1]}}, b_rd_q};
  assign prod  = a_ext * b_ext;

`ifdef MATMUL_SAT_EN
  logic clip, out_clip_q, sat_seen_q;

  generate
    if (OUT_W < ACC_W) begin : g_sat
      always_comb begin
        conv = acc_q[OUT_W-1:0];
        clip = 1'b0;
        if (sgn_q) begin
          if (acc_q[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){acc_q[ACC_W-1]}}) begin
            clip = 1'b1;
            conv = acc_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
          end
        end else if (|acc_q[ACC_W-1:OUT_W]) begin
          clip = 1'b1;
          conv = '1;
        end
      end
    end else begin : g_nosat
      assign conv = acc_q[OUT_W-1:0];
      assign clip = 1'b0;
    end
  endgenerate

  assign sat_seen = sat_seen_q;
`else
  logic unused_acc;
  assign conv       = acc_q[OUT_W-1:0];
  assign unused_acc = ^acc_q;
`endif

  // Operand buffers carry no reset so they can map onto RAM.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD_A && in_fire && !abort)
      a_mem[ci_q[c_mi-1:0]][ck_q[c_ki-1:0]] <= s_if.in_data;
    if (state_q == S_LOAD_B && in_fire && !abort)
      b_mem[ck_q[c_ki-1:0]][cj_q[c_ni-1:0]] <= s_if.in_data;
    if (state_q == S_COMPUTE && !stall) begin
      a_rd_q <= a_mem[ci_q[c_mi-1:0]][ck_q[c_ki-1:0]];
      b_rd_q <= b_mem[ck_q[c_ki-1:0]][cj_q[c_ni-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      ci_q        <= '0;
      ck_q        <= '0;
      cj_q        <= '0;
      sgn_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_v_q      <= 1'b0;
      rd_first_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_lastel_q <= 1'b0;
      seq_done_q  <= 1'b0;
      acc_done_q  <= 1'b0;
      acc_last_q  <= 1'b0;
      acc_q       <= '0;
`ifdef MATMUL_SAT_EN
      out_clip_q  <= 1'b0;
      sat_seen_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        state_q     <= S_IDLE;
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        ci_q        <= '0;
        ck_q        <= '0;
        cj_q        <= '0;
        rd_v_q      <= 1'b0;
        seq_done_q  <= 1'b0;
        acc_done_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (start_bad) begin
                err_q <= 1'b1;
              end else begin
                m_q        <= M_in;
                k_q        <= K_in;
                n_q        <= N_in;
                sgn_q      <= is_signed;
                in_ready_q <= 1'b1;
                state_q    <= S_LOAD_A;
`ifdef MATMUL_SAT_EN
                sat_seen_q <= 1'b0;
`endif
              end
            end
          end
          S_LOAD_A: begin
            if (in_fire) begin
              if (ck_q == k_q - 1'b1) begin
                ck_q <= '0;
                if (ci_q == m_q - 1'b1) begin
                  ci_q    <= '0;
                  state_q <= S_LOAD_B;
                end else begin
                  ci_q <= ci_q + 1'b1;
                end
              end else begin
                ck_q <= ck_q + 1'b1;
              end
            end
          end
          S_LOAD_B: begin
            if (in_fire) begin
              if (cj_q == n_q - 1'b1) begin
                cj_q <= '0;
                if (ck_q == k_q - 1'b1) begin
                  ck_q       <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_COMPUTE;
                end else begin
                  ck_q <= ck_q + 1'b1;
                end
              end else begin
                cj_q <= cj_q + 1'b1;
              end
            end
          end
          S_COMPUTE: begin
            if (out_fire)
              out_valid_q <= 1'b0;
            if (load_out) begin
              out_data_q  <= conv;
              out_valid_q <= 1'b1;
              out_last_q  <= acc_last_q;
              acc_done_q  <= 1'b0;
`ifdef MATMUL_SAT_EN
              out_clip_q  <= clip;
`endif
            end
`ifdef MATMUL_SAT_EN
            if (out_fire && out_clip_q)
              sat_seen_q <= 1'b1;
`endif
            // Each element spends K read slots plus one idle slot (ck == K).
            if (!stall) begin
              rd_v_q      <= !seq_done_q && (ck_q < k_q);
              rd_first_q  <= (ck_q == '0);
              rd_last_q   <= (ck_q == k_q - 1'b1);
              rd_lastel_q <= (ci_q == m_q - 1'b1) && (cj_q == n_q - 1'b1);
              if (!seq_done_q) begin
                if (ck_q == k_q) begin
                  ck_q <= '0;
                  if (cj_q == n_q - 1'b1) begin
                    cj_q <= '0;
                    if (ci_q == m_q - 1'b1) begin
                      ci_q       <= '0;
                      seq_done_q <= 1'b1;
                    end else begin
                      ci_q <= ci_q + 1'b1;
                    end
                  end else begin
                    cj_q <= cj_q + 1'b1;
                  end
                end else begin
                  ck_q <= ck_q + 1'b1;
                end
              end
              if (rd_v_q) begin
                acc_q <= (rd_first_q ? '0 : acc_q) + prod;
                if (rd_last_q) begin
                  acc_done_q <= 1'b1;
                  acc_last_q <= rd_lastel_q;
                end
              end
            end
            if (out_fire && out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
              seq_done_q  <= 1'b0;
              rd_v_q      <= 1'b0;
              acc_done_q  <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign s_if.in_ready  = in_ready_q;
  assign s_if.out_valid = out_valid_q;
  assign s_if.out_data  = out_data_q;
  assign s_if.out_last  = out_last_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_stream_engine
// Purpose  : Directed self-checking bench for matmul_stream_engine (OUT_W=16).
// Revision : 1.0
// ============================================================================
module tb_matmul_stream_engine;
  localparam int OUT_W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       is_signed = 1'b0;
  logic [4:0] M_in = '0, K_in = '0, N_in = '0;
  logic       busy, done, err;
`ifdef MATMUL_SAT_EN
  logic       sat_seen;
`endif

  matmul_stream_engine_if #(.DATA_W(16), .OUT_W(OUT_W)) bus ();

  matmul_stream_engine #(.OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .is_signed (is_signed),
    .M_in      (M_in),
    .K_in      (K_in),
    .N_in      (N_in),
    .s_if      (bus),
    .busy      (busy),
    .done      (done),
`ifdef MATMUL_SAT_EN
    .sat_seen  (sat_seen),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [15:0]      beats[$];
  logic [OUT_W-1:0] got[$];
  logic             got_last[$];
  int               lat, stab_err, early_done;
  logic             done_at, done_next, valid_at, busy_at;

  task automatic start_job(input int m, input int k, input int n, input bit sgn);
    start = 1'b1; M_in = 5'(m); K_in = 5'(k); N_in = 5'(n); is_signed = sgn;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beats();
    int g;
    foreach (beats[i]) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beats[i];
      g = 0;
      while (!bus.in_ready && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout beat %0d in_ready got 0 want 1", i);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input bit toggle, input int budget);
    int               cyc;
    bit               hold;
    logic [OUT_W-1:0] hd;
    logic             hl;
    got.delete(); got_last.delete();
    lat = -1; stab_err = 0; early_done = 0; cyc = 0; hold = 0; hd = '0; hl = 1'b0;
    bus.out_ready = toggle ? 1'b0 : 1'b1;
    while (got.size() < n && cyc < budget) begin
      if (bus.out_valid && lat < 0) lat = cyc;
      if (done) early_done++;
      if (hold && (!bus.out_valid || bus.out_data !== hd || bus.out_last !== hl)) stab_err++;
      hold = 0;
      if (toggle) bus.out_ready = ~bus.out_ready;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
      end else if (bus.out_valid) begin
        hold = 1; hd = bus.out_data; hl = bus.out_last;
      end
      @(negedge clk); cyc++;
    end
    done_at = done; valid_at = bus.out_valid; busy_at = busy;
    @(negedge clk);
    done_next = done;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [OUT_W-1:0] exp_c[4];
    exp_c = '{16'd58, 16'd64, 16'd139, 16'd154};
    start_job(2, 3, 2, 1'b0);
    beats = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12};
    send_beats();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL uns_in_ready_drop got %b want 0", bus.in_ready); end
    collect(4, 1'b0, 100);
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL uns_latency got %0d want 5", lat); end
    n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL uns_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== exp_c[i]) begin n_bad++; $display("FAIL uns_c%0d got %0d want %0d", i, got[i], exp_c[i]); end
    end
    n_cmp++; if ({got_last[0], got_last[1], got_last[2], got_last[3]} !== 4'b0001) begin
      n_bad++; $display("FAIL uns_last got %b%b%b%b want 0001", got_last[0], got_last[1], got_last[2], got_last[3]); end
    n_cmp++; if (early_done != 0) begin n_bad++; $display("FAIL uns_early_done got %0d want 0", early_done); end
    n_cmp++; if (done_at !== 1'b1) begin n_bad++; $display("FAIL uns_done got %b want 1", done_at); end
    n_cmp++; if (done_next !== 1'b0) begin n_bad++; $display("FAIL uns_done_width got %b want 0", done_next); end
    n_cmp++; if (valid_at !== 1'b0 || busy_at !== 1'b0) begin
      n_bad++; $display("FAIL uns_idle_after got valid=%b busy=%b want 0 0", valid_at, busy_at); end
  endtask

  task automatic test_signed();
    start_job(1, 2, 1, 1'b1);
    beats = '{16'hFFFD, 16'd2, 16'd5, 16'hFFFC};
    send_beats();
    collect(1, 1'b0, 50);
    n_cmp++; if (got[0] !== 16'hFFE9) begin n_bad++; $display("FAIL sgn_c got %h want ffe9", got[0]); end
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL sgn_latency got %0d want 4", lat); end
    n_cmp++; if (got_last[0] !== 1'b1) begin n_bad++; $display("FAIL sgn_last got %b want 1", got_last[0]); end
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] exp_c[4];
    exp_c = '{16'd58, 16'd64, 16'd139, 16'd154};
    start_job(2, 3, 2, 1'b0);
    beats = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12};
    send_beats();
    collect(4, 1'b1, 200);
    n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL bp_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== exp_c[i]) begin n_bad++; $display("FAIL bp_c%0d got %0d want %0d", i, got[i], exp_c[i]); end
    end
    n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
    n_cmp++; if (got_last[3] !== 1'b1) begin n_bad++; $display("FAIL bp_last got %b want 1", got_last[3]); end
    n_cmp++; if (done_at !== 1'b1) begin n_bad++; $display("FAIL bp_done got %b want 1", done_at); end
  endtask

  task automatic test_illegal();
    int m_v[2];
    int k_v[2];
    m_v = '{2, 17};
    k_v = '{0, 2};
    for (int t = 0; t < 2; t++) begin
      start_job(m_v[t], k_v[t], 2, 1'b0);
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ill%0d_err got %b want 1", t, err); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ill%0d_busy got %b want 0", t, busy); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL ill%0d_in_ready got %b want 0", t, bus.in_ready); end
      @(negedge clk);
      n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL ill%0d_after got err=%b busy=%b want 0 0", t, err, busy); end
    end
  endtask

  task automatic test_abort();
    int g;
    start_job(2, 3, 2, 1'b0);
    beats = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    send_beats();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL abl_idle got busy=%b in_ready=%b want 0 0", busy, bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL abl_quiet got valid=%b done=%b want 0 0", bus.out_valid, done); end

    bus.out_ready = 1'b0;
    start_job(2, 3, 2, 1'b0);
    beats = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12};
    send_beats();
    g = 0;
    while (!bus.out_valid && g < 50) begin @(negedge clk); g++; end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL abc_wait_valid got %b want 1", bus.out_valid); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL abc_idle got busy=%b valid=%b want 0 0", busy, bus.out_valid); end
    n_cmp++; if (done !== 1'b0 || bus.out_last !== 1'b0) begin
      n_bad++; $display("FAIL abc_quiet got done=%b last=%b want 0 0", done, bus.out_last); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abc_no_done got %b want 0", done); end

    start_job(1, 1, 1, 1'b0);
    beats = '{16'd3, 16'd4};
    send_beats();
    collect(1, 1'b0, 50);
    n_cmp++; if (got[0] !== 16'd12) begin n_bad++; $display("FAIL post_abort_c got %0d want 12", got[0]); end
    n_cmp++; if (got_last[0] !== 1'b1) begin n_bad++; $display("FAIL post_abort_last got %b want 1", got_last[0]); end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL post_abort_latency got %0d want 3", lat); end
    n_cmp++; if (done_at !== 1'b1) begin n_bad++; $display("FAIL post_abort_done got %b want 1", done_at); end
  endtask

  task automatic test_saturation();
    logic [OUT_W-1:0] exp_s, exp_u;
`ifdef MATMUL_SAT_EN
    exp_s = 16'h7FFF;
    exp_u = 16'hFFFF;
`else
    exp_s = 16'h0002;
    exp_u = 16'h5F90;
`endif
    start_job(1, 2, 1, 1'b1);
    beats = '{16'd32767, 16'd32767, 16'd32767, 16'd32767};
    send_beats();
    collect(1, 1'b0, 50);
    n_cmp++; if (got[0] !== exp_s) begin n_bad++; $display("FAIL sat_signed got %h want %h", got[0], exp_s); end
`ifdef MATMUL_SAT_EN
    n_cmp++; if (sat_seen !== 1'b1) begin n_bad++; $display("FAIL sat_seen_signed got %b want 1", sat_seen); end
`endif
    start_job(1, 1, 1, 1'b0);
    beats = '{16'd300, 16'd300};
    send_beats();
    collect(1, 1'b0, 50);
    n_cmp++; if (got[0] !== exp_u) begin n_bad++; $display("FAIL sat_unsigned got %h want %h", got[0], exp_u); end
    start_job(1, 1, 1, 1'b0);
    beats = '{16'd2, 16'd3};
    send_beats();
    collect(1, 1'b0, 50);
    n_cmp++; if (got[0] !== 16'd6) begin n_bad++; $display("FAIL sat_clean got %0d want 6", got[0]); end
`ifdef MATMUL_SAT_EN
    n_cmp++; if (sat_seen !== 1'b0) begin n_bad++; $display("FAIL sat_seen_cleared got %b want 0", sat_seen); end
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_illegal();
    test_abort();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
